io_output_bank: RTL and testbench
=================================

IO_OUTPUT_BANK -- requirements
Module: io_output_bank

Interface
REQ-001 The module SHALL have parameter R, default 2, meaning number of output registers.
REQ-002 The module SHALL have parameter T, default 8, meaning bits per output register.
REQ-003 The module SHALL have parameter N, default 1, meaning selection width; N >= ceil(log2(R)).
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 The module SHALL have port wr_req, input, 1 bit, write request (four-phase).
REQ-007 The module SHALL have port selection, input, N bits, target register index.
REQ-008 The module SHALL have port datain, input, T bits, write data.
REQ-009 The module SHALL have port wr_ack, output, 1 bit, registered write acknowledge.
REQ-010 The module SHALL have port sel_err, output, 1 bit, marking an out-of-range selection; valid while wr_ack=1.
REQ-011 The module SHALL have port dataout, output, R*T bits, concatenated registers; register i is dataout[i*T+T-1 : i*T].
REQ-012 The module SHALL have port update, output, R bits, one-cycle pulse on bit i when register i is written.

Function
REQ-013 The module SHALL implement states IDLE, WRITE and DONE.
REQ-014 In IDLE with wr_req=1, the module SHALL capture selection and datain into holding registers on that edge and go to WRITE.
REQ-015 In IDLE with wr_req=0, the module SHALL hold all registers and outputs unchanged.
REQ-016 In WRITE with a valid held selection s (s < R), the module SHALL load the held data into register s on the next edge, leave all other registers unchanged, and go to DONE.
REQ-017 In WRITE with an invalid held selection (s >= R), the module SHALL write no register, keep update at 0, set sel_err=1, and go to DONE.
REQ-018 update[s] SHALL be high for exactly the one cycle following the WRITE edge, aligned with the first cycle of wr_ack=1.
REQ-019 update SHALL be one-hot or zero at all times.
REQ-020 In DONE, wr_ack SHALL be 1 and the module SHALL stay in DONE while wr_req=1.
REQ-021 In DONE with wr_req=0, the module SHALL return to IDLE on that edge, with wr_ack and sel_err cleared to 0 on the same edge.
REQ-022 Latency SHALL be: wr_req first sampled high at edge E0, register updated and wr_ack high after edge E0+1 (two edges from request to ack).
REQ-023 The module SHALL ignore changes on selection and datain after E0 until the next IDLE acceptance.
REQ-024 The module SHALL NOT accept a new write until wr_req has been low in DONE; a wr_req held high SHALL produce exactly one write.
REQ-025 A write to a register SHALL fully replace its contents; dataout SHALL be driven directly from the registers, with no combinational path from datain.
REQ-026 When R is not a power of two, selections from R to 2^N-1 SHALL be treated as invalid.

Reset
REQ-027 While reset=1 at a rising edge, the module SHALL set state to IDLE, all registers in dataout to 0, update to 0, wr_ack to 0 and sel_err to 0.
REQ-028 Reset SHALL take priority over every state; a reset during WRITE or DONE SHALL abort the transaction without writing any register on that edge.
REQ-029 After reset is released, a wr_req that is still high SHALL be treated as a new request in IDLE.

Verification
REQ-030 Basic write: with R=2, T=8, N=1, after reset, wr_req=1, selection=1, datain=8'hA5 -> after 2 edges dataout=16'hA500, update=2'b10 for 1 cycle, wr_ack=1, sel_err=0; drop wr_req -> wr_ack=0 the next cycle.
REQ-031 Two writes: write 8'h3C to register 0, then 8'hFF to register 1 -> dataout=16'hFF3C; update pulses 2'b01 then 2'b10.
REQ-032 Held request: keep wr_req=1 for 10 cycles while changing datain every cycle -> exactly one update pulse, with the register holding the data sampled at E0.
REQ-033 Invalid selection: with R=3, N=2, selection=3 -> wr_ack=1, sel_err=1, update=0, dataout unchanged.
REQ-034 Reset mid-operation: assert reset in the WRITE cycle of a write of 8'h77 to register 0 -> register 0 stays 8'h00, wr_ack stays 0, state is IDLE.
REQ-035 Reset values: with dataout=16'h1234, assert reset for 1 edge -> dataout=0, update=0, wr_ack=0, sel_err=0.

Source files
------------

// File: rtl/io_output_bank.sv
// Bank of R output registers of T bits, written one at a time through a
// four-phase wr_req/wr_ack handshake with an IDLE -> WRITE -> DONE sequence.
module io_output_bank #(
  parameter int R = 2,
  parameter int T = 8,
  parameter int N = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_req,
  input  logic [N-1:0]   selection,
  input  logic [T-1:0]   datain,
  output logic           wr_ack,
  output logic           sel_err,
  output logic [R*T-1:0] dataout,
  output logic [R-1:0]   update
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t       state;
  logic [N-1:0] sel_h;
  logic [T-1:0] data_h;
  logic [R-1:0] hit;

  // Decode of the held selection; all-zero when the index is out of range.
  always_comb begin
    hit = '0;
    for (int i = 0; i < R; i++) hit[i] = (sel_h == N'(i));
  end

  // Request snapshot, taken only on IDLE acceptance so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_req) begin
      sel_h  <= selection;
      data_h <= datain;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dataout <= '0;
      update  <= '0;
      wr_ack  <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          update <= '0;
          if (wr_req) state <= WRITE;
        end
        WRITE: begin
          for (int i = 0; i < R; i++)
            if (hit[i]) dataout[i*T +: T] <= data_h;
          update  <= hit;
          sel_err <= ~|hit;
          wr_ack  <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          update <= '0;
          if (!wr_req) begin
            state   <= IDLE;
            wr_ack  <= 1'b0;
            sel_err <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_output_bank.sv
// Bench for io_output_bank: a 2x8 (N=1) and a 3x8 (N=2) instance share one
// stimulus stream and are compared against per-register array models.
module tb_io_output_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_req;
  logic [1:0]  sel;
  logic [7:0]  datain;

  logic        ack2, err2, ack3, err3;
  logic [15:0] dout2;
  logic [23:0] dout3;
  logic [1:0]  upd2;
  logic [2:0]  upd3;

  logic [7:0]  m2 [2];
  logic [7:0]  m3 [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_output_bank #(.R(2), .T(8), .N(1)) u2 (
    .clk(clk), .reset(reset), .wr_req(wr_req), .selection(sel[0:0]),
    .datain(datain), .wr_ack(ack2), .sel_err(err2), .dataout(dout2), .update(upd2)
  );

  io_output_bank #(.R(3), .T(8), .N(2)) u3 (
    .clk(clk), .reset(reset), .wr_req(wr_req), .selection(sel),
    .datain(datain), .wr_ack(ack3), .sel_err(err3), .dataout(dout3), .update(upd3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_models();
    for (int i = 0; i < 2; i++) m2[i] = 8'h00;
    for (int i = 0; i < 3; i++) m3[i] = 8'h00;
  endtask

  task automatic chk_data(input string tag);
    chk({tag, "_dout2"}, 64'(dout2), 64'({m2[1], m2[0]}));
    chk({tag, "_dout3"}, 64'(dout3), 64'({m3[2], m3[1], m3[0]}));
  endtask

  task automatic chk_quiet(input string tag, input logic ack);
    chk({tag, "_ack2"}, 64'(ack2), 64'(ack));
    chk({tag, "_ack3"}, 64'(ack3), 64'(ack));
    chk({tag, "_upd2"}, 64'(upd2), 64'd0);
    chk({tag, "_upd3"}, 64'(upd3), 64'd0);
    chk_data(tag);
  endtask

  // One complete handshake; wr_req stays high for `hold` extra cycles in DONE
  // while selection/datain are scrambled every cycle.
  task automatic write_txn(input string tag, input logic [1:0] s, input logic [7:0] d,
                           input int hold);
    int v3;
    wr_req = 1'b1; sel = s; datain = d;
    step();
    sel = 2'($urandom); datain = 8'($urandom);
    chk_quiet({tag, "_e0"}, 1'b0);
    step();
    v3 = (s < 2'd3) ? 1 : 0;
    m2[s[0]] = d;
    if (v3 == 1) m3[s] = d;
    chk({tag, "_ack2"}, 64'(ack2), 64'd1);
    chk({tag, "_ack3"}, 64'(ack3), 64'd1);
    chk({tag, "_err2"}, 64'(err2), 64'd0);
    chk({tag, "_err3"}, 64'(err3), 64'(v3 == 0));
    chk({tag, "_upd2"}, 64'(upd2), 64'(2 ** int'(s[0])));
    chk({tag, "_upd3"}, 64'(upd3), (v3 == 1) ? 64'(2 ** int'(s)) : 64'd0);
    chk_data(tag);
    for (int k = 0; k < hold; k++) begin
      sel = 2'($urandom); datain = 8'($urandom);
      step();
      chk_quiet({tag, "_hold"}, 1'b1);
      chk({tag, "_hold_err3"}, 64'(err3), 64'(v3 == 0));
    end
    wr_req = 1'b0;
    step();
    chk_quiet({tag, "_rel"}, 1'b0);
    chk({tag, "_rel_err3"}, 64'(err3), 64'd0);
  endtask

  initial begin
    reset = 1'b1; wr_req = 1'b0; sel = '0; datain = '0;
    clear_models();
    step(); step();
    chk_quiet("reset", 1'b0);
    chk("reset_err3", 64'(err3), 64'd0);
    reset = 1'b0;
    step();
    chk_quiet("idle", 1'b0);

    write_txn("basic", 2'd1, 8'hA5, 0);
    chk("basic_value", 64'(dout2), 64'hA500);

    write_txn("two_a", 2'd0, 8'h3C, 1);
    write_txn("two_b", 2'd1, 8'hFF, 0);
    chk("two_value", 64'(dout2), 64'hFF3C);

    write_txn("held", 2'd0, 8'h5A, 9);
    chk("held_value", 64'(dout2), 64'hFF5A);

    write_txn("badsel", 2'd3, 8'hC3, 2);

    write_txn("r2", 2'd2, 8'h81, 0);

    write_txn("rv_a", 2'd1, 8'h12, 0);
    write_txn("rv_b", 2'd0, 8'h34, 0);
    chk("rv_value", 64'(dout2), 64'h1234);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_models();
    chk_quiet("rv_after", 1'b0);
    chk("rv_err3", 64'(err3), 64'd0);

    // Reset lands on the WRITE edge; the still-high request restarts afterwards.
    wr_req = 1'b1; sel = 2'd0; datain = 8'h77;
    step();
    reset = 1'b1;
    step();
    chk_quiet("midrst", 1'b0);
    reset = 1'b0;
    step();
    chk_quiet("midrst_e0", 1'b0);
    step();
    m2[0] = 8'h77; m3[0] = 8'h77;
    chk("midrst_ack", 64'(ack2), 64'd1);
    chk("midrst_upd3", 64'(upd3), 64'd1);
    chk_data("midrst_wr");
    wr_req = 1'b0;
    step();
    chk_quiet("midrst_rel", 1'b0);

    for (int n = 0; n < 25; n++) begin
      write_txn("rand", 2'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) begin
        step();
        chk_quiet("rand_idle", 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
